// File: rtl/mem_dump_tx_pkg.sv
// Shared types and constants for the data-memory serial dump port.
// Holds the sequencer state encoding, the 8N1 line levels and the frame builder.
package mem_dump_tx_pkg;

    typedef enum logic [2:0] {
        MDT_IDLE,
        MDT_READ,
        MDT_WAIT,
        MDT_LOAD,
        MDT_SEND,
        MDT_CSUM,
        MDT_FIN
    } mdt_state_t;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_FRAME_BITS = 10;

    // Bit 0 goes on the line first, so the start bit sits at the bottom.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
        return {UART_STOP_BIT, data, UART_START_BIT};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: owns the bit timer and bit counter.
// ready is high whenever a new byte may be loaded, including the final stop-bit cycle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       ready
);
    import mem_dump_tx_pkg::*;

    localparam int             TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TMAX = TW'(CLKS_PER_BIT - 1);

    logic [UART_FRAME_BITS-1:0] frame;
    logic [3:0]                 bitcnt;
    logic [TW-1:0]              timer;
    logic                       active;
    logic                       last;

    // Accepting a load in the last stop-bit cycle keeps consecutive bytes gap-free.
    assign last  = active && (timer == TMAX) && (bitcnt == 4'(UART_FRAME_BITS - 1));
    assign ready = !active || last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx     <= UART_STOP_BIT;
            frame  <= '0;
            bitcnt <= '0;
            timer  <= '0;
            active <= 1'b0;
        end else if (load && ready) begin
            frame  <= uart_frame(byte_in);
            tx     <= UART_START_BIT;
            bitcnt <= '0;
            timer  <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (timer == TMAX) begin
                timer <= '0;
                if (last) begin
                    active <= 1'b0;
                    bitcnt <= '0;
                    tx     <= UART_STOP_BIT;
                end else begin
                    bitcnt <= bitcnt + 4'd1;
                    tx     <= frame[1];
                    frame  <= {UART_STOP_BIT, frame[UART_FRAME_BITS-1:1]};
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// Reads a word range from datamem and streams it out LSB-first, words little-endian.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module mem_dump_tx #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tx
);
    import mem_dump_tx_pkg::*;

    localparam int BPW = DATA_W / 8;
    localparam int BCW = $clog2(BPW + 1);

    mdt_state_t        state;
    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] next_shift;
    logic [BCW-1:0]    bytes_left;
    logic [ADDR_W-1:0] words_left;
    logic              more_bytes;
    logic              more_words;
    logic              load;
    logic              ready;
    logic [7:0]        byte_in;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]        cksum;
`endif

    assign next_shift = shifter >> 8;
    assign more_bytes = (bytes_left != '0);
    assign more_words = (words_left > ADDR_W'(1));

    // The next byte is handed over in the sender's last stop-bit cycle so a word has no gaps.
    always_comb begin
        load    = 1'b0;
        byte_in = shifter[7:0];
        case (state)
            MDT_LOAD: load = 1'b1;
            MDT_SEND: begin
                if (ready) begin
                    if (more_bytes) begin
                        load    = 1'b1;
                        byte_in = next_shift[7:0];
                    end
`ifdef MEM_DUMP_CHECKSUM_EN
                    else if (!more_words) begin
                        load    = 1'b1;
                        byte_in = cksum;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MDT_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            shifter    <= '0;
            bytes_left <= '0;
            words_left <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                MDT_IDLE: begin
                    if (start) begin
                        words_left <= word_count;
                        mem_addr   <= base_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                        cksum      <= '0;
`endif
                        if (word_count == '0) begin
                            state <= MDT_FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= MDT_READ;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                MDT_READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= MDT_WAIT;
                end
                MDT_WAIT: begin
                    shifter <= mem_rd_data;
                    state   <= MDT_LOAD;
                end
                MDT_LOAD: begin
                    bytes_left <= BCW'(BPW - 1);
                    state      <= MDT_SEND;
`ifdef MEM_DUMP_CHECKSUM_EN
                    cksum      <= cksum ^ byte_in;
`endif
                end
                MDT_SEND: begin
                    if (ready) begin
                        if (more_bytes) begin
                            shifter    <= next_shift;
                            bytes_left <= bytes_left - BCW'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
                            cksum      <= cksum ^ byte_in;
`endif
                        end else if (more_words) begin
                            words_left <= words_left - ADDR_W'(1);
                            mem_addr   <= mem_addr + ADDR_W'(1);
                            mem_rd_en  <= 1'b1;
                            state      <= MDT_READ;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            state <= MDT_CSUM;
`else
                            state <= MDT_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                MDT_CSUM: begin
                    if (ready) begin
                        state <= MDT_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                MDT_FIN: state <= MDT_IDLE;
                default: state <= MDT_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .byte_in(byte_in),
        .tx     (tx),
        .ready  (ready)
    );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx with a 1-cycle-latency datamem model and a serial decoder.
// Expected checksum bytes are used only when MEM_DUMP_CHECKSUM_EN is defined.
module tb_mem_dump_tx;

    localparam int CPB = 4;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  word_count = '0;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic        tx;

    mem_dump_tx #(
        .DATA_W      (32),
        .ADDR_W      (10),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic [9:0] addr_q[$];
    int done_cnt, done_cyc, busy_cnt, low_cnt, frame_err;
    int mon_active, mon_cnt;
    logic [7:0] mon_byte;
    int compared = 0;
    int mismatched = 0;

    // Serial decoder and event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 0;
        end else begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            if (mem_rd_en) addr_q.push_back(mem_addr);
            if (tx == 1'b0) low_cnt++;
            if (mon_active == 0) begin
                if (tx == 1'b0) begin
                    mon_active = 1;
                    mon_cnt = 0;
                    rx_start.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == CPB/2 && tx != 1'b0) frame_err++;
                for (int j = 1; j <= 8; j++)
                    if (mon_cnt == CPB*j + CPB/2) mon_byte[j-1] = tx;
                if (mon_cnt == 9*CPB + CPB/2) begin
                    if (tx != 1'b1) frame_err++;
                    rx_q.push_back(mon_byte);
                    mon_active = 0;
                end
            end
        end
    end

    typedef struct packed {
        logic [9:0]  base;
        logic [9:0]  count;
        int          nb;
        logic [63:0] bytes;
        logic [7:0]  cks;
        int          naddr;
        logic [9:0]  a0;
        logic [9:0]  a1;
        int          busy;
        int          dl;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        rx_q.delete();
        rx_start.delete();
        addr_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        low_cnt = 0;
        frame_err = 0;
    endtask

    task automatic applyStimulus(input logic [9:0] b, input logic [9:0] c, input int repulse,
                                 output int s, output bit got_done);
        @(negedge clk); #1;
        clearMonitor();
        base_addr = b;
        word_count = c;
        start = 1'b1;
        s = cyc;
        got_done = 1'b0;
        for (int i = 1; i < 3000; i++) begin
            @(negedge clk); #1;
            if (i == repulse) begin
                start = 1'b1;
                base_addr = 10'd7;
                word_count = 10'd5;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
    endtask

    task automatic checkVector(input vec_t v, input int s, input bit got_done, input string tag);
        int extra;
        extra = (v.nb > 0) ? CS : 0;
        checkOutput({tag, "_done_seen"}, 32'(got_done), 1);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_done_latency"}, done_cyc - s, v.dl + extra*10*CPB);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, v.busy + extra*10*CPB);
        checkOutput({tag, "_byte_count"}, rx_q.size(), v.nb + extra);
        for (int i = 0; i < v.nb; i++)
            if (i < rx_q.size())
                checkOutput($sformatf("%s_byte%0d", tag, i), rx_q[i], v.bytes[8*i +: 8]);
`ifdef MEM_DUMP_CHECKSUM_EN
        if (v.nb > 0 && rx_q.size() > v.nb)
            checkOutput({tag, "_checksum"}, rx_q[v.nb], v.cks);
`endif
        checkOutput({tag, "_read_count"}, addr_q.size(), v.naddr);
        if (v.naddr > 0 && addr_q.size() > 0) checkOutput({tag, "_addr0"}, addr_q[0], v.a0);
        if (v.naddr > 1 && addr_q.size() > 1) checkOutput({tag, "_addr1"}, addr_q[1], v.a1);
        if (v.nb > 0 && rx_start.size() > 0)
            checkOutput({tag, "_first_byte_latency"}, rx_start[0] - s, 4);
        if (v.nb == 8 && rx_start.size() >= 5) begin
            checkOutput({tag, "_intra_word_spacing"}, rx_start[1] - rx_start[0], 10*CPB);
            checkOutput({tag, "_inter_word_spacing"}, rx_start[4] - rx_start[3], 10*CPB + 3);
        end
        if (v.nb == 0) checkOutput({tag, "_tx_low_samples"}, low_cnt, 0);
        checkOutput({tag, "_frame_errors"}, frame_err, 0);
        checkOutput({tag, "_tx_idle_after"}, 32'(tx), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  s;
        bit  gd;

        for (int i = 0; i < 1024; i++) ram[i] = 32'hA5A5_0000 | 32'(i);
        ram[2]    = 32'h0000_0005;
        ram[3]    = 32'h1234_5678;
        ram[1023] = 32'hA1B2_C3D4;
        ram[0]    = 32'h0F0E_0D0C;

        vecs[0] = '{base: 10'd2,   count: 10'd1, nb: 4, bytes: 64'h0000_0000_0000_0005, cks: 8'h05,
                    naddr: 1, a0: 10'd2,   a1: 10'd0, busy: 163, dl: 164};
        vecs[1] = '{base: 10'd2,   count: 10'd2, nb: 8, bytes: 64'h1234_5678_0000_0005, cks: 8'h0D,
                    naddr: 2, a0: 10'd2,   a1: 10'd3, busy: 326, dl: 327};
        vecs[2] = '{base: 10'h3FF, count: 10'd2, nb: 8, bytes: 64'h0F0E_0D0C_A1B2_C3D4, cks: 8'h04,
                    naddr: 2, a0: 10'h3FF, a1: 10'd0, busy: 326, dl: 327};
        vecs[3] = '{base: 10'd0,   count: 10'd0, nb: 0, bytes: 64'h0,                   cks: 8'h00,
                    naddr: 0, a0: 10'd0,   a1: 10'd0, busy: 0,   dl: 1};

        #12;
        checkOutput("reset_tx", 32'(tx), 1);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_rd_en", 32'(mem_rd_en), 0);
        checkOutput("reset_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k].base, vecs[k].count, 0, s, gd);
            checkVector(vecs[k], s, gd, $sformatf("vec%0d", k));
        end

        $display("[TB] start re-pulsed mid-dump");
        applyStimulus(10'd2, 10'd2, 100, s, gd);
        checkVector(vecs[1], s, gd, "repulse");

        $display("[TB] start held through FIN");
        @(negedge clk); #1;
        clearMonitor();
        word_count = 10'd0;
        start = 1'b1;
        s = cyc;
        repeat (3) @(negedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("fin_start_done_pulses", done_cnt, 2);
        checkOutput("fin_start_second_done", done_cyc - s, 3);
        checkOutput("fin_start_busy", busy_cnt, 0);
        checkOutput("fin_start_reads", addr_q.size(), 0);

        $display("[TB] reset during bit 3");
        @(negedge clk); #1;
        clearMonitor();
        base_addr = 10'd2;
        word_count = 10'd1;
        start = 1'b1;
        s = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        while (cyc < s + 21) @(negedge clk);
        #1;
        checkOutput("mid_bit3_low", 32'(tx), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", 32'(tx), 1);
        checkOutput("async_reset_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        clearMonitor();
        repeat (200) @(negedge clk);
        #1;
        checkOutput("post_reset_tx_low", low_cnt, 0);
        checkOutput("post_reset_busy", busy_cnt, 0);
        checkOutput("post_reset_done", done_cnt, 0);
        checkOutput("post_reset_addr", 32'(mem_addr), 0);

        applyStimulus(vecs[0].base, vecs[0].count, 0, s, gd);
        checkVector(vecs[0], s, gd, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
